// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, majority-voted bits) feeding a first-word fall-through FIFO.
// Frame format, line rate and buffer depth are parameters; framing, parity and overflow errors pulse for one cycle.
module uart_rx_fifo #(
    parameter int  CLK_HZ     = 100000000,
    parameter int  BAUD       = 115200,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1,
    parameter int  FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [AW:0]          count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow
);

    localparam int          DIV       = CLK_HZ / (BAUD * 16);
    localparam int          TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, rxprev_q;
    logic [TW-1:0]          tick_cnt_q;
    logic [3:0]             samp_q, samp_d;
    logic [3:0]             bit_q, bit_d;
    logic                   s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_bad_q, par_bad_d;
    logic                   stop_bad_q, stop_bad_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overflow_q, overflow_d;
    logic                   restart, push, pop;
    logic                   tick, mid, last, maj, rx_s;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q;

    assign rx_s = sync2_q;
    assign tick = (tick_cnt_q == TICK_LAST);
    assign mid  = tick && (samp_q == 4'd9);
    assign last = tick && (samp_q == 4'd15);
    // Vote uses the two stored samples plus the live one taken on the mid tick.
    assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

    always_ff @(posedge clk_in) begin
        if (rst || restart || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        s7_d         = s7_q;
        s8_d         = s8_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overflow_d   = 1'b0;
        restart      = 1'b0;
        push         = 1'b0;

        if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd7) s7_d = rx_s;
            if (samp_q == 4'd8) s8_d = rx_s;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rxprev_q && !rx_s) begin
                    state_d    = S_START;
                    samp_d     = 4'd0;
                    bit_d      = 4'd0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    restart    = 1'b1;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (mid) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (last) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (mid) par_bad_d = (((^shreg_q) ^ maj) != (PARITY == 1));
                if (last) begin
                    bit_d   = 4'd0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave on the last stop bit's mid sample so the next start edge is never missed.
                if (mid) begin
                    if (!maj) stop_bad_d = 1'b1;
                    if (bit_q == STOP_LAST) state_d = S_DONE;
                end else if (last) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (stop_bad_q) begin
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end else if (par_bad_q) begin
                    parity_err_d = 1'b1;
                end else if (!full || rd_en) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rxprev_q     <= 1'b1;
            state_q      <= S_IDLE;
            samp_q       <= 4'd0;
            bit_q        <= 4'd0;
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            rxprev_q     <= sync2_q;
            state_q      <= state_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk_in) begin
        shreg_q <= shreg_d;
    end

    // A push into a full FIFO is only possible alongside a pop, so the write slot is already freed.
    assign pop = rd_en && !empty;

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign empty      = (count_q == '0);
    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign count      = count_q;
    assign rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

endmodule
